// File: rtl/apu_frame_counter.sv
// APU frame sequencer: quarter/half-frame strobes, the $4017 mode/inhibit register
// and the frame IRQ flag (cleared through $4015 reads).
module apu_frame_counter #(
  parameter int unsigned STEP1 = 7457,
  parameter int unsigned STEP2 = 14913,
  parameter int unsigned STEP3 = 22371,
  parameter int unsigned STEP4 = 29829,
  parameter int unsigned STEP5 = 37281,
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_ce,
  input  logic       reg_wr,
  input  logic [7:0] reg_data,
  input  logic       irq_ack,
  output logic       qtrframe,
  output logic       halfframe,
  output logic       irq,
  output logic       mode
);

  localparam logic [CNT_W-1:0] S1   = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2   = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3   = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4   = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S4M1 = CNT_W'(STEP4 - 1);
  localparam logic [CNT_W-1:0] S5   = CNT_W'(STEP5);

  // Remaining CPU cycles before a $4017 write takes effect.
  typedef enum logic [2:0] {
    CD_IDLE = 3'd0,
    CD_1    = 3'd1,
    CD_2    = 3'd2,
    CD_3    = 3'd3,
    CD_4    = 3'd4
  } cd_state_t;

  cd_state_t        cd_state, cd_next;
  logic             expiry;
  logic [CNT_W-1:0] cnt;
  logic             mode_q, pend_mode, inhibit, irq_q;
  logic             qtr_q, half_q, parity, wrap_q;
  logic             at_last, step_q, step_h, irq_set;

  always_ff @(posedge clk) begin
    if (rst) cd_state <= CD_IDLE;
    else     cd_state <= cd_next;
  end

  // A write on the same CPU cycle as expiry reloads instead of expiring.
  always_comb begin
    cd_next = cd_state;
    expiry  = 1'b0;
    if (cpu_ce) begin
      if (reg_wr) begin
        cd_next = parity ? CD_4 : CD_3;
      end else begin
        unique case (cd_state)
          CD_4:    cd_next = CD_3;
          CD_3:    cd_next = CD_2;
          CD_2:    cd_next = CD_1;
          CD_1: begin
            cd_next = CD_IDLE;
            expiry  = 1'b1;
          end
          default: cd_next = CD_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    at_last = (cnt == (mode_q ? S5 : S4));
    step_q  = (cnt == S1) || (cnt == S2) || (cnt == S3) || at_last;
    step_h  = (cnt == S2) || at_last;
    irq_set = !mode_q && !inhibit &&
              ((cnt == S4M1) || (cnt == S4) || ((cnt == '0) && wrap_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      mode_q    <= 1'b0;
      pend_mode <= 1'b0;
      inhibit   <= 1'b0;
      irq_q     <= 1'b0;
      qtr_q     <= 1'b0;
      half_q    <= 1'b0;
      parity    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      qtr_q  <= 1'b0;
      half_q <= 1'b0;
      if (cpu_ce) begin
        parity <= ~parity;
        if (expiry) begin
          cnt    <= '0;
          mode_q <= pend_mode;
          wrap_q <= 1'b0;
          qtr_q  <= pend_mode;
          half_q <= pend_mode;
        end else begin
          cnt    <= at_last ? '0 : cnt + CNT_W'(1);
          wrap_q <= !mode_q && at_last;
          qtr_q  <= step_q;
          half_q <= step_h;
        end
        if (reg_wr && reg_data[6])      irq_q <= 1'b0;
        else if (irq_set && !expiry)    irq_q <= 1'b1;
        else if (irq_ack)               irq_q <= 1'b0;
        if (reg_wr) begin
          inhibit   <= reg_data[6];
          pend_mode <= reg_data[7];
        end
      end
    end
  end

  assign qtrframe  = qtr_q;
  assign halfframe = half_q;
  assign irq       = irq_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Self-checking bench for apu_frame_counter using scaled-down step counts.
module tb_apu_frame_counter;

  localparam int P1 = 74;
  localparam int P2 = 149;
  localparam int P3 = 223;
  localparam int P4 = 298;
  localparam int P5 = 372;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_ce = 1'b0;
  logic       reg_wr = 1'b0;
  logic [7:0] reg_data = '0;
  logic       irq_ack = 1'b0;
  logic       qtrframe, halfframe, irq, mode;

  apu_frame_counter #(
    .STEP1(P1), .STEP2(P2), .STEP3(P3), .STEP4(P4), .STEP5(P5), .CNT_W(9)
  ) dut (
    .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .reg_wr(reg_wr), .reg_data(reg_data),
    .irq_ack(irq_ack), .qtrframe(qtrframe), .halfframe(halfframe), .irq(irq), .mode(mode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame position plus an absolute-cycle deadline for pending writes.
  int m_pos, m_cyc, m_pend_at;
  bit m_mode, m_inh, m_irq, m_par, m_pend, m_pend_mode, m_wrapped;
  bit e_q, e_h;
  int steps[3] = '{P1, P2, P3};

  function automatic void model_reset();
    m_pos = 0; m_cyc = 0; m_pend_at = 0;
    m_mode = 0; m_inh = 0; m_irq = 0; m_par = 0;
    m_pend = 0; m_pend_mode = 0; m_wrapped = 0;
    e_q = 0; e_h = 0;
  endfunction

  function automatic void model_cycle(bit wr, logic [7:0] d, bit ack);
    bit expire, set;
    int last;
    e_q = 0; e_h = 0; set = 0;
    expire = m_pend && !wr && (m_cyc == m_pend_at);
    last = m_mode ? P5 : P4;
    if (expire) begin
      m_pos = 0; m_mode = m_pend_mode; m_wrapped = 0; m_pend = 0;
      e_q = m_mode; e_h = m_mode;
    end else begin
      foreach (steps[i]) if (m_pos == steps[i]) begin e_q = 1; if (i == 1) e_h = 1; end
      if (m_pos == last) begin e_q = 1; e_h = 1; end
      set = !m_mode && !m_inh && (m_pos == P4 - 1 || m_pos == P4 || (m_pos == 0 && m_wrapped));
      m_wrapped = !m_mode && (m_pos == P4);
      m_pos = (m_pos == last) ? 0 : m_pos + 1;
    end
    if (wr && d[6]) m_irq = 0;
    else if (set)   m_irq = 1;
    else if (ack)   m_irq = 0;
    if (wr) begin
      m_inh = d[6]; m_pend = 1; m_pend_mode = d[7];
      m_pend_at = m_cyc + (m_par ? 4 : 3);
    end
    m_par = !m_par;
    m_cyc++;
  endfunction

  task automatic tick(input bit ce, input bit wr, input logic [7:0] d, input bit ack);
    cpu_ce = ce; reg_wr = wr; reg_data = d; irq_ack = ack;
    if (ce) model_cycle(wr, d, ack);
    else begin e_q = 0; e_h = 0; end
    @(posedge clk); #1;
    cpu_ce = 0; reg_wr = 0; irq_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1; cpu_ce = 1'($urandom); reg_wr = 1'($urandom); reg_data = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst = 0; cpu_ce = 0; reg_wr = 0; irq_ack = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({qtrframe, halfframe, irq, mode} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset outputs got=%b required=0000", {qtrframe, halfframe, irq, mode});
    end
  endtask

  task automatic test_four_step();
    int nq = 0, nh = 0, first_q = -1;
    bit a;
    do_reset();
    for (int k = 1; k <= 2 * (P4 + 1); k++) begin
      a = (k <= P4 + 1 && m_pos == P4) || (k > P4 + 1 && m_pos == 5);
      tick(1, 0, 8'h00, a);
      n_cmp++;
      if ({qtrframe, halfframe, irq, mode} !== {e_q, e_h, m_irq, m_mode}) begin
        n_bad++;
        $display("FAIL four_step k=%0d q/h/irq/mode got=%b required=%b", k,
                 {qtrframe, halfframe, irq, mode}, {e_q, e_h, m_irq, m_mode});
      end
      if (qtrframe) begin nq++; if (first_q < 0) first_q = k; end
      if (halfframe) nh++;
      if (a) begin
        n_cmp++;
        if (irq !== (k <= P4 + 1)) begin
          n_bad++;
          $display("FAIL irq_ack k=%0d irq got=%b required=%b", k, irq, (k <= P4 + 1));
        end
      end
    end
    n_cmp++;
    if (nq != 8 || nh != 4 || first_q != P1 + 1) begin
      n_bad++;
      $display("FAIL four_step_tally q=%0d h=%0d first=%0d required 8 4 %0d", nq, nh, first_q, P1 + 1);
    end
  endtask

  task automatic test_five_step();
    int nq = 0, nh = 0, nirq = 0;
    do_reset();
    tick(1, 1, 8'h80, 0);
    for (int k = 1; k <= 2 * (P5 + 1) + 4; k++) begin
      tick(1, 0, 8'h00, 1'($urandom_range(0, 19) == 0));
      n_cmp++;
      if ({qtrframe, halfframe, irq, mode} !== {e_q, e_h, m_irq, m_mode}) begin
        n_bad++;
        $display("FAIL five_step k=%0d q/h/irq/mode got=%b required=%b", k,
                 {qtrframe, halfframe, irq, mode}, {e_q, e_h, m_irq, m_mode});
      end
      if (k == 3) begin
        n_cmp++;
        if ({qtrframe, halfframe, mode} !== 3'b111) begin
          n_bad++;
          $display("FAIL five_step_switch q/h/mode got=%b required=111", {qtrframe, halfframe, mode});
        end
      end
      if (qtrframe) nq++;
      if (halfframe) nh++;
      if (irq) nirq++;
    end
    n_cmp++;
    if (nq != 9 || nh != 5 || nirq != 0) begin
      n_bad++;
      $display("FAIL five_step_tally q=%0d h=%0d irq=%0d required 9 5 0", nq, nh, nirq);
    end
  endtask

  task automatic test_slow_ce();
    int nq = 0, wide = 0;
    bit prev_q = 0;
    do_reset();
    tick(1, 0, 8'h00, 0);
    tick(1, 1, 8'h80, 0);
    for (int nce = 1; nce <= 4 + P5 + 1; nce++) begin
      for (int s = 0; s < 3; s++) begin
        tick(s == 2, 0, 8'h00, 0);
        n_cmp++;
        if ({qtrframe, halfframe, irq, mode} !== {e_q, e_h, m_irq, m_mode}) begin
          n_bad++;
          $display("FAIL slow_ce nce=%0d s=%0d q/h/irq/mode got=%b required=%b", nce, s,
                   {qtrframe, halfframe, irq, mode}, {e_q, e_h, m_irq, m_mode});
        end
        if (qtrframe) nq++;
        if (qtrframe && prev_q) wide++;
        prev_q = qtrframe;
      end
    end
    n_cmp++;
    if (nq != 5 || wide != 0) begin
      n_bad++;
      $display("FAIL slow_ce_tally q=%0d wide=%0d required 5 0", nq, wide);
    end
  endtask

  task automatic test_inhibit();
    int nirq = 0;
    do_reset();
    repeat (P4) tick(1, 0, 8'h00, 0);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL inhibit_pre irq got=%b required=1", irq);
    end
    tick(1, 1, 8'h40, 0);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL inhibit_clear irq got=%b required=0", irq);
    end
    for (int k = 1; k <= 2 * (P4 + 1) + 6; k++) begin
      tick(1, 0, 8'h00, 1'($urandom_range(0, 9) == 0));
      n_cmp++;
      if ({qtrframe, halfframe, irq, mode} !== {e_q, e_h, m_irq, m_mode}) begin
        n_bad++;
        $display("FAIL inhibit k=%0d q/h/irq/mode got=%b required=%b", k,
                 {qtrframe, halfframe, irq, mode}, {e_q, e_h, m_irq, m_mode});
      end
      if (irq) nirq++;
    end
    n_cmp++;
    if (nirq != 0) begin
      n_bad++;
      $display("FAIL inhibit_tally irq_high=%0d required 0", nirq);
    end
  endtask

  task automatic test_back_to_back();
    int nq = 0, nh = 0;
    do_reset();
    repeat (10) tick(1, 0, 8'h00, 0);
    tick(1, 1, 8'h00, 0);
    repeat (2) tick(1, 0, 8'h00, 0);
    tick(1, 1, 8'h80, 0);
    for (int k = 1; k <= 10; k++) begin
      tick(1, 0, 8'h00, 0);
      n_cmp++;
      if ({qtrframe, halfframe, irq, mode} !== {e_q, e_h, m_irq, m_mode}) begin
        n_bad++;
        $display("FAIL rewrite k=%0d q/h/irq/mode got=%b required=%b", k,
                 {qtrframe, halfframe, irq, mode}, {e_q, e_h, m_irq, m_mode});
      end
      if (qtrframe) nq++;
      if (halfframe) nh++;
    end
    n_cmp++;
    if (nq != 1 || nh != 1 || mode !== 1'b1) begin
      n_bad++;
      $display("FAIL rewrite_tally q=%0d h=%0d mode=%b required 1 1 1", nq, nh, mode);
    end
    tick(1, 1, 8'h80, 0);
    tick(1, 0, 8'h00, 0);
    do_reset();
    do_reset();
    nq = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1, 0, 8'h00, 0);
      if (qtrframe || halfframe || mode) nq++;
    end
    n_cmp++;
    if (nq != 0) begin
      n_bad++;
      $display("FAIL reset_mid_countdown stray_cycles=%0d required 0", nq);
    end
  endtask

  task automatic test_random();
    bit ce, wr, ack;
    logic [7:0] d;
    do_reset();
    for (int k = 0; k < 5000; k++) begin
      ce  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 299) == 0);
      ack = 1'($urandom_range(0, 49) == 0);
      d   = 8'($urandom);
      tick(ce, wr, d, ack);
      n_cmp++;
      if ({qtrframe, halfframe, irq, mode} !== {e_q, e_h, m_irq, m_mode}) begin
        n_bad++;
        $display("FAIL random k=%0d q/h/irq/mode got=%b required=%b", k,
                 {qtrframe, halfframe, irq, mode}, {e_q, e_h, m_irq, m_mode});
      end
    end
  endtask

  initial begin
    test_reset();
    test_four_step();
    test_five_step();
    test_slow_ce();
    test_inhibit();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
